reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 14 +
 rtl/reset_sequencer_sync_2ff.sv | 13 +
 rtl/reset_sequencer.sv | 120 ++++++++++++
 tb/tb_reset_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state type, counter width, default timings and saturating increment
package reset_seq_pkg;
  localparam int CNT_W = 16;
  localparam int WZ_W = 8;
  localparam int DEF_LOCK_STABLE_CYCLES = 16;
  localparam int DEF_RESET_HOLD_CYCLES = 8;
  localparam int DEF_WD_TIMEOUT_CYCLES = 1000;
  localparam int DEF_WZ_RESET_CYCLES = 4;
  typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, HOLD, RUN} state_t;
  typedef logic [CNT_W-1:0] cnt_t;
  function automatic cnt_t sat_inc(cnt_t c);
    return (c == '1) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level, cleared by async reset
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the async level through two flops to settle metastability
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds downstream reset until the clock wizard lock is stable; RESET_SEQ_WATCHDOG_EN adds a lock watchdog
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES = DEF_RESET_HOLD_CYCLES,
  parameter int WD_TIMEOUT_CYCLES = DEF_WD_TIMEOUT_CYCLES,
  parameter int WZ_RESET_CYCLES = DEF_WZ_RESET_CYCLES
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_locked,
  input  logic i_soft_reset,
  output logic o_reset,
  output logic o_ready,
  output logic o_wz_reset,
  output logic o_lock_timeout
);
  localparam cnt_t STAB_LAST = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam cnt_t HOLD_LAST = cnt_t'(RESET_HOLD_CYCLES - 1);
  state_t state, state_d;
  cnt_t cnt, cnt_d;
  logic locked_s;

  if (LOCK_STABLE_CYCLES < 1 || LOCK_STABLE_CYCLES > 65535 ||
      RESET_HOLD_CYCLES < 1 || RESET_HOLD_CYCLES > 65535 ||
      WD_TIMEOUT_CYCLES < 1 || WD_TIMEOUT_CYCLES > 65535 ||
      WZ_RESET_CYCLES < 1 || WZ_RESET_CYCLES > 255) begin : g_bad_params
    $error("reset_sequencer: timing parameter out of range");
  end

  sync_2ff u_sync (
    .clk(i_clock),
    .rst_n(i_reset),
    .d(i_locked),
    .q(locked_s)
  );

  // next state and phase counter; lock loss overrides soft reset everywhere
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    case (state)
      WAIT_LOCK: if (locked_s) begin
        state_d = STABILIZE;
        cnt_d = '0;
      end
      STABILIZE: if (!locked_s) begin
        state_d = WAIT_LOCK;
        cnt_d = '0;
      end else if (cnt == STAB_LAST) begin
        state_d = HOLD;
        cnt_d = '0;
      end else cnt_d = sat_inc(cnt);
      HOLD: if (!locked_s) begin
        state_d = WAIT_LOCK;
        cnt_d = '0;
      end else if (i_soft_reset) cnt_d = '0;
      else if (cnt == HOLD_LAST) begin
        state_d = RUN;
        cnt_d = '0;
      end else cnt_d = sat_inc(cnt);
      RUN: if (!locked_s) begin
        state_d = WAIT_LOCK;
        cnt_d = '0;
      end else if (i_soft_reset) begin
        state_d = HOLD;
        cnt_d = '0;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d = '0;
      end
    endcase
  end

  // state, counter and registered reset/ready move on the same edge
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state <= WAIT_LOCK;
      cnt <= '0;
      o_reset <= 1'b1;
      o_ready <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      o_reset <= state_d != RUN;
      o_ready <= state_d == RUN;
    end

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam cnt_t WD_LAST = cnt_t'(WD_TIMEOUT_CYCLES);
  localparam logic [WZ_W-1:0] WZ_LAST = WZ_W'(WZ_RESET_CYCLES - 1);
  cnt_t wd_cnt;
  logic [WZ_W-1:0] wz_cnt;
  logic wd_run, wd_fire, wz_done, enter_hold, enter_run;
  assign wd_run = state == WAIT_LOCK || state == STABILIZE;
  assign wd_fire = !o_wz_reset && wd_cnt == WD_LAST;
  assign wz_done = o_wz_reset && wz_cnt == WZ_LAST;
  assign enter_hold = state_d == HOLD && state != HOLD;
  assign enter_run = state_d == RUN && state != RUN;

  // watchdog counts while waiting for lock, pulses the wizard reset, restarts after the pulse
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      wd_cnt <= '0;
      wz_cnt <= '0;
      o_wz_reset <= 1'b0;
      o_lock_timeout <= 1'b0;
    end else begin
      wd_cnt <= (enter_hold || wz_done) ? '0 : (wd_run && !o_wz_reset && !wd_fire) ? sat_inc(wd_cnt) : wd_cnt;
      wz_cnt <= (o_wz_reset && !wz_done) ? wz_cnt + 1'b1 : '0;
      o_wz_reset <= wd_fire || (o_wz_reset && !wz_done);
      o_lock_timeout <= !enter_run && (o_lock_timeout || wd_fire);
    end
`else
  assign o_wz_reset = 1'b0;
  assign o_lock_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench; stimulus queues expected output changes by edge, a monitor matches them
module tb_reset_sequencer;
  import reset_seq_pkg::*;
  typedef struct {
    int edge_n;
    logic [3:0] val;
  } exp_t;

  logic i_clock = 1'b0;
  logic i_reset = 1'b0;
  logic i_locked = 1'b0;
  logic i_soft_reset = 1'b0;
  logic o_reset, o_ready, o_wz_reset, o_lock_timeout;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  exp_t exp_q[$];
  exp_t e_mon;
  logic [3:0] cur;
  logic [3:0] prev = 4'b1000;

  reset_sequencer dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_locked(i_locked),
    .i_soft_reset(i_soft_reset),
    .o_reset(o_reset),
    .o_ready(o_ready),
    .o_wz_reset(o_wz_reset),
    .o_lock_timeout(o_lock_timeout)
  );

  always #5 i_clock = ~i_clock;

  // rising-edge index used to timestamp every expected output change
  always @(posedge i_clock) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  function automatic void expect_at(int e, logic [3:0] val);
    exp_q.push_back('{e, val});
  endfunction

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge i_clock);
  endtask

  // monitor: {o_reset,o_ready,o_wz_reset,o_lock_timeout} changes are matched against the queue
  initial forever begin
    @(negedge i_clock);
    cur = {o_reset, o_ready, o_wz_reset, o_lock_timeout};
    if (cur !== prev) begin
      if (exp_q.size() == 0) chk("unexpected_change", {32'(cyc), 28'b0, cur}, {32'(cyc), 28'b0, prev});
      else begin
        e_mon = exp_q.pop_front();
        chk("output_change", {32'(cyc), 28'b0, cur}, {32'(e_mon.edge_n), 28'b0, e_mon.val});
      end
    end else if (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
      e_mon = exp_q.pop_front();
      chk("missed_change", {32'(cyc), 28'b0, cur}, {32'(e_mon.edge_n), 28'b0, e_mon.val});
    end
    prev = cur;
  end

  initial begin
    int r, c, s, u, v, w, x;
    repeat (2) @(negedge i_clock);
    chk("rst_o_reset", 64'(o_reset), 64'(1));
    chk("rst_o_ready", 64'(o_ready), 64'(0));
    chk("rst_o_wz_reset", 64'(o_wz_reset), 64'(0));
    chk("rst_o_lock_timeout", 64'(o_lock_timeout), 64'(0));
    chk("rst_state", 64'(dut.state), 64'(WAIT_LOCK));
    wait_cyc(3);
    i_reset = 1'b1;
    r = cyc;
`ifdef RESET_SEQ_WATCHDOG_EN
    // lock held low: wizard reset high on cycles 1001..1004 after release, timeout flag sticks
    expect_at(r + 1001, 4'b1011);
    expect_at(r + 1005, 4'b1001);
    wait_cyc(r + 1010);
`else
    wait_cyc(r + 5);
`endif
    // first sampling edge is c+1, so release lands on edge c+1+26
    i_locked = 1'b1;
    c = cyc;
    expect_at(c + 27, 4'b0100);
    wait_cyc(c + 40);
    // soft reset sampled on edges s+1..s+5: HOLD from s+1, counter restarts after s+5, RUN on s+13
    s = cyc;
    i_soft_reset = 1'b1;
    expect_at(s + 1, 4'b1000);
    expect_at(s + 13, 4'b0100);
    wait_cyc(s + 5);
    i_soft_reset = 1'b0;
    wait_cyc(s + 25);
    // lock loss reaches the FSM on u+3 together with soft reset; lock loss wins
    u = cyc;
    i_locked = 1'b0;
    wait_cyc(u + 2);
    i_soft_reset = 1'b1;
    expect_at(u + 3, 4'b1000);
    wait_cyc(u + 3);
    chk("lockloss_state", 64'(dut.state), 64'(WAIT_LOCK));
    wait_cyc(u + 8);
    chk("lockloss_state_held", 64'(dut.state), 64'(WAIT_LOCK));
    i_soft_reset = 1'b0;
    // 3-cycle lock dropout while stabilizing restarts the full sequence
    v = cyc;
    i_locked = 1'b1;
    wait_cyc(v + 5);
    chk("glitch_in_stabilize", 64'(dut.state), 64'(STABILIZE));
    i_locked = 1'b0;
    wait_cyc(v + 8);
    chk("glitch_back_to_wait", 64'(dut.state), 64'(WAIT_LOCK));
    i_locked = 1'b1;
    expect_at(v + 35, 4'b0100);
    wait_cyc(v + 45);
    // async reset in the middle of HOLD
    w = cyc;
    i_soft_reset = 1'b1;
    expect_at(w + 1, 4'b1000);
    wait_cyc(w + 1);
    i_soft_reset = 1'b0;
    wait_cyc(w + 4);
    chk("hold_before_reset", 64'(dut.state), 64'(HOLD));
    #2 i_reset = 1'b0;
    #1;
    chk("async_o_reset", 64'(o_reset), 64'(1));
    chk("async_o_ready", 64'(o_ready), 64'(0));
    chk("async_o_wz_reset", 64'(o_wz_reset), 64'(0));
    chk("async_o_lock_timeout", 64'(o_lock_timeout), 64'(0));
    chk("async_state", 64'(dut.state), 64'(WAIT_LOCK));
    chk("async_cnt", 64'(dut.cnt), 64'(0));
    chk("async_locked_s", 64'(dut.locked_s), 64'(0));
    wait_cyc(w + 7);
    i_reset = 1'b1;
    x = cyc;
    expect_at(x + 27, 4'b0100);
    wait_cyc(x + 35);
    chk("pending_expectations", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
